// File: rtl/view_draw_sequencer.sv
// Per-frame draw scheduler for the REPL terminal view: snapshots view state on a frame tick,
// issues ordered draw commands over valid/ready and owns the timed status-message lifetime.
// Optional footer command is enabled with DRAW_FOOTER_EN.
module view_draw_sequencer #(
    parameter int unsigned FRAME_RATE = 30,
    parameter int unsigned LINE_W     = 8,
    parameter int unsigned COL_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic              fixed,
    input  logic [LINE_W-1:0] out_len,
    input  logic [COL_W-1:0]  in_len,
    input  logic [COL_W-1:0]  in_offset,
    input  logic [COL_W-1:0]  prompt_len,
    input  logic [COL_W-1:0]  footer_len,
    input  logic [COL_W-1:0]  win_w,
    input  logic [LINE_W-1:0] win_h,
    input  logic              msg_req,
    input  logic [3:0]        msg_time,
    input  logic              msg_clr,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [2:0]        cmd_op,
    output logic [COL_W-1:0]  cmd_x,
    output logic [LINE_W-1:0] cmd_y,
    output logic [LINE_W-1:0] in_linen,
    output logic [LINE_W-1:0] out_linen,
    output logic              msg_active,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    localparam int unsigned LW1  = LINE_W + 1;
    localparam int unsigned CW2  = COL_W + 2;
    localparam int unsigned FL_W = $clog2(15 * FRAME_RATE + 1);

    localparam logic [2:0] OP_MSG    = 3'd0;
    localparam logic [2:0] OP_OUTPUT = 3'd1;
    localparam logic [2:0] OP_INPUT  = 3'd2;
    localparam logic [2:0] OP_FOOTER = 3'd3;
    localparam logic [2:0] OP_CURSOR = 3'd4;

`ifdef DRAW_FOOTER_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MSG    = 3'd1,
        S_OUTPUT = 3'd2,
        S_INPUT  = 3'd3,
        S_FOOTER = 3'd4,
        S_CURSOR = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MSG    = 3'd1,
        S_OUTPUT = 3'd2,
        S_INPUT  = 3'd3,
        S_CURSOR = 3'd5
    } state_t;
`endif

    state_t state_q, state_d;

    logic              valid_d;
    logic [2:0]        op_d;
    logic [COL_W-1:0]  x_d;
    logic [LINE_W-1:0] y_d;
    logic              done_d;
    logic              accept;
    logic              advance;

    logic [LW1-1:0]    out_len_inc;
    logic [LW1-1:0]    live_in_inc;
    logic [LINE_W-1:0] live_in;
    logic [LINE_W-1:0] live_out;
    logic [LINE_W-1:0] live_msg_y;
    logic [COL_W-1:0]  off_clamp;
    logic [CW2-1:0]    cur_sum;
    logic [COL_W-1:0]  live_cur_x;
    logic [COL_W-1:0]  snap_cur_x;
    logic [FL_W-1:0]   frames_left;

    assign accept  = (state_q == S_IDLE) && frame_tick;
    assign advance = cmd_valid && cmd_ready;

    // Positions and payloads computed from the live inputs at the accepting tick
    always_comb begin
        out_len_inc = {1'b0, out_len} + LW1'(1);
        if (fixed) begin
            live_in  = LINE_W'(1);
            live_out = LINE_W'(2);
        end else begin
            live_in  = out_len_inc[LINE_W] ? '1 : out_len_inc[LINE_W-1:0];
            live_out = LINE_W'(1);
        end
        live_in_inc = {1'b0, live_in} + LW1'(1);
        live_msg_y  = live_in_inc[LINE_W] ? '1 : live_in_inc[LINE_W-1:0];
        off_clamp   = (in_offset > in_len) ? in_len : in_offset;
        cur_sum     = CW2'(prompt_len) + CW2'(2) + CW2'(in_len - off_clamp);
        live_cur_x  = (cur_sum[CW2-1:COL_W] != '0) ? '1 : cur_sum[COL_W-1:0];
    end

`ifdef DRAW_FOOTER_EN
    logic [COL_W-1:0]  foot_half;
    logic [COL_W-1:0]  live_foot_x;
    logic [COL_W-1:0]  snap_foot_x;
    logic [LINE_W-1:0] snap_foot_y;

    always_comb begin
        foot_half = (win_w - footer_len) >> 1;
        if ((footer_len >= win_w) || (foot_half == '0)) begin
            live_foot_x = COL_W'(1);
        end else begin
            live_foot_x = foot_half;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_foot_x <= '0;
            snap_foot_y <= '0;
        end else if (accept) begin
            snap_foot_x <= live_foot_x;
            snap_foot_y <= win_h;
        end
    end
`else
    logic unused_footer;
    assign unused_footer = ^{footer_len, win_h};
`endif

    // Next state and next command payload
    always_comb begin
        state_d = state_q;
        valid_d = cmd_valid;
        op_d    = cmd_op;
        x_d     = cmd_x;
        y_d     = cmd_y;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    valid_d = 1'b1;
                    x_d     = COL_W'(1);
                    if (msg_active) begin
                        state_d = S_MSG;
                        op_d    = OP_MSG;
                        y_d     = live_msg_y;
                    end else begin
                        state_d = S_OUTPUT;
                        op_d    = OP_OUTPUT;
                        y_d     = live_out;
                    end
                end
            end
            S_MSG: begin
                if (advance) begin
                    state_d = S_OUTPUT;
                    op_d    = OP_OUTPUT;
                    x_d     = COL_W'(1);
                    y_d     = out_linen;
                end
            end
            S_OUTPUT: begin
                if (advance) begin
                    state_d = S_INPUT;
                    op_d    = OP_INPUT;
                    x_d     = COL_W'(1);
                    y_d     = in_linen;
                end
            end
            S_INPUT: begin
                if (advance) begin
`ifdef DRAW_FOOTER_EN
                    state_d = S_FOOTER;
                    op_d    = OP_FOOTER;
                    x_d     = snap_foot_x;
                    y_d     = snap_foot_y;
`else
                    state_d = S_CURSOR;
                    op_d    = OP_CURSOR;
                    x_d     = snap_cur_x;
                    y_d     = in_linen;
`endif
                end
            end
`ifdef DRAW_FOOTER_EN
            S_FOOTER: begin
                if (advance) begin
                    state_d = S_CURSOR;
                    op_d    = OP_CURSOR;
                    x_d     = snap_cur_x;
                    y_d     = in_linen;
                end
            end
`endif
            S_CURSOR: begin
                if (advance) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    op_d    = '0;
                    x_d     = '0;
                    y_d     = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cmd_valid  <= 1'b0;
            cmd_op     <= '0;
            cmd_x      <= '0;
            cmd_y      <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_valid  <= valid_d;
            cmd_op     <= op_d;
            cmd_x      <= x_d;
            cmd_y      <= y_d;
            busy       <= (state_d != S_IDLE);
            frame_done <= done_d;
            overrun    <= frame_tick && (state_q != S_IDLE);
        end
    end

    // Per-frame snapshot; line positions double as the sequence's stored rows
    always_ff @(posedge clk) begin
        if (rst) begin
            in_linen   <= LINE_W'(1);
            out_linen  <= LINE_W'(1);
            snap_cur_x <= '0;
        end else if (accept) begin
            in_linen   <= live_in;
            out_linen  <= live_out;
            snap_cur_x <= live_cur_x;
        end
    end

    // Message lifetime in frames; zero frames_left with msg_active set means persistent
    always_ff @(posedge clk) begin
        if (rst) begin
            frames_left <= '0;
            msg_active  <= 1'b0;
        end else if (msg_req) begin
            frames_left <= FL_W'(32'(msg_time) * FRAME_RATE);
            msg_active  <= 1'b1;
        end else if (msg_clr) begin
            frames_left <= '0;
            msg_active  <= 1'b0;
        end else if (frame_tick && (frames_left != '0)) begin
            frames_left <= frames_left - FL_W'(1);
            if (frames_left == FL_W'(1)) begin
                msg_active <= 1'b0;
            end
        end
    end

endmodule
